// File: rtl/bch_pkg.sv
// Shared constants and FSM state type for the BCH(63,51) t=2 encoder.
package bch_pkg;

  localparam int N = 63;
  localparam int K = 51;
  localparam int P = 12;
  localparam logic [12:0] GPOLY = 13'h1539;

  typedef enum logic {
    LOAD = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/bch_parity_calc.sv
// Combinational parity r = (m(x) * x^P) mod g(x), evaluated as an unrolled LFSR walk MSB first.
module bch_parity_calc #(
  parameter int K = bch_pkg::K,
  parameter int P = bch_pkg::P,
  parameter logic [P:0] GPOLY = bch_pkg::GPOLY
) (
  input  logic [K-1:0] msg,
  output logic [P-1:0] parity
);

  logic [P-1:0] rem;
  logic         fb;

  always_comb begin
    rem = '0;
    fb  = 1'b0;
    for (int i = K - 1; i >= 0; i--) begin
      fb  = msg[i] ^ rem[P-1];
      rem = {rem[P-2:0], 1'b0} ^ ({P{fb}} & GPOLY[P-1:0]);
    end
  end

  assign parity = rem;

endmodule

// File: rtl/bch_encoder.sv
// Systematic BCH(63,51) encoder: registered parallel path plus a handshaked serial LOAD/SEND path.
//
// state | meaning
// LOAD  | accept message bits (ready_in), advance parity LFSR
// SEND  | present codeword MSB first on data_out (valid_out)
module bch_encoder
  import bch_pkg::*;
#(
  parameter int N = bch_pkg::N,
  parameter int K = bch_pkg::K,
  parameter int P = bch_pkg::P,
  parameter logic [P:0] GPOLY = bch_pkg::GPOLY
) (
  input  logic         clk,
  input  logic         rst,
  output logic         ready_in,
  input  logic         ready_out,
  input  logic         valid_in,
  output logic         valid_out,
  input  logic         data_in,
  input  logic [K-1:0] data_in_all,
  output logic [N-1:0] data_out_all,
  output logic         data_out
);

  localparam logic [5:0] LOAD_TC = 6'(K - 1);
  localparam logic [5:0] SEND_TC = 6'(N - 1);

  state_t       state;
  logic [5:0]   cnt;
  logic [P-1:0] lfsr;
  logic [P-1:0] lfsr_nxt;
  logic         fb;
  logic [N-1:0] out_sr;
  logic [P-1:0] par_all;
  logic         accept;
  logic         xfer;

  bch_parity_calc #(
    .K     (K),
    .P     (P),
    .GPOLY (GPOLY)
  ) u_parity_calc (
    .msg    (data_in_all),
    .parity (par_all)
  );

  assign accept = (state == LOAD) && valid_in && ready_in;
  assign xfer   = (state == SEND) && ready_out;

  always_comb begin
    fb       = data_in ^ lfsr[P-1];
    lfsr_nxt = {lfsr[P-2:0], 1'b0} ^ ({P{fb}} & GPOLY[P-1:0]);
  end

  // During LOAD the low K bits of out_sr act as the message register, so the
  // codeword is formed in place by appending the final parity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= LOAD;
      cnt          <= '0;
      lfsr         <= '0;
      out_sr       <= '0;
      data_out_all <= '0;
      data_out     <= 1'b0;
      valid_out    <= 1'b0;
      ready_in     <= 1'b0;
    end else begin
      data_out_all <= {data_in_all, par_all};
      case (state)
        LOAD: begin
          ready_in <= 1'b1;
          if (accept) begin
            lfsr <= lfsr_nxt;
            if (cnt == LOAD_TC) begin
              out_sr    <= {out_sr[K-2:0], data_in, lfsr_nxt};
              data_out  <= out_sr[K-2];
              cnt       <= '0;
              ready_in  <= 1'b0;
              valid_out <= 1'b1;
              state     <= SEND;
            end else begin
              out_sr <= {out_sr[N-2:0], data_in};
              cnt    <= cnt + 6'd1;
            end
          end
        end
        SEND: begin
          if (xfer) begin
            out_sr <= {out_sr[N-2:0], 1'b0};
            if (cnt == SEND_TC) begin
              cnt       <= '0;
              lfsr      <= '0;
              data_out  <= 1'b0;
              valid_out <= 1'b0;
              ready_in  <= 1'b1;
              state     <= LOAD;
            end else begin
              cnt      <= cnt + 6'd1;
              data_out <= out_sr[N-2];
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_bch_encoder.sv
// Directed bench for bch_encoder: parallel vectors, serial handshake with gaps, reset abort, linearity.
module tb_bch_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready_in;
  logic        ready_out;
  logic        valid_in;
  logic        valid_out;
  logic        data_in;
  logic [50:0] data_in_all;
  logic [62:0] data_out_all;
  logic        data_out;

  int checks = 0;
  int fails  = 0;

  localparam logic [50:0] LONG_MSG = 51'b011011011110110110001111011001011110011001101100011;

  bch_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .ready_in     (ready_in),
    .ready_out    (ready_out),
    .valid_in     (valid_in),
    .valid_out    (valid_out),
    .data_in      (data_in),
    .data_in_all  (data_in_all),
    .data_out_all (data_out_all),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [62:0] obs, input logic [62:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Long division of c(x) by g(x); returns the 12-bit remainder.
  function automatic logic [11:0] poly_rem(input logic [62:0] c_in);
    logic [62:0] c;
    logic [62:0] g;
    c = c_in;
    g = 63'h1539;
    for (int i = 62; i >= 12; i--)
      if (c[i]) c = c ^ (g << (i - 12));
    return c[11:0];
  endfunction

  function automatic logic [62:0] model_cw(input logic [50:0] m);
    return {m, poly_rem({m, 12'b0})};
  endfunction

  task automatic load_msg(input logic [50:0] m, input int nbits, input int gap, output logic to);
    int done = 0;
    int cyc  = 0;
    while (done < nbits && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      valid_in = (gap == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap);
      data_in  = m[50 - done];
      if (valid_in && ready_in) done++;
    end
    to = (done < nbits);
  endtask

  task automatic collect(input int gap, output logic [62:0] cw, output logic rdy_bad,
                         output logic hold_bad, output logic to);
    int   bits = 0;
    int   cyc  = 0;
    logic pv   = 1'b0;
    logic px   = 1'b0;
    logic pd   = 1'b0;
    cw       = '0;
    rdy_bad  = 1'b0;
    hold_bad = 1'b0;
    while (bits < 63 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      valid_in = 1'b0;
      data_in  = 1'b0;
      if (valid_out && ready_in) rdy_bad = 1'b1;
      if (pv && !px && valid_out && (data_out !== pd)) hold_bad = 1'b1;
      ready_out = (gap == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap);
      pv = valid_out;
      pd = data_out;
      px = valid_out && ready_out;
      if (valid_out && ready_out) begin
        cw = {cw[61:0], data_out};
        bits++;
      end
    end
    to = (bits < 63);
    @(negedge clk);
    ready_out = 1'b0;
  endtask

  initial begin
    logic [62:0] cw;
    logic [62:0] ca, cb, cab;
    logic [50:0] a, b;
    logic [63:0] r64;
    logic        to, rdy_bad, hold_bad, seen_valid;

    rst         = 1'b0;
    ready_out   = 1'b0;
    valid_in    = 1'b0;
    data_in     = 1'b0;
    data_in_all = 51'h7_1234_5678_9ABC;
    repeat (3) @(negedge clk);

    check("rst_ready_in", 63'(ready_in), 63'd0);
    check("rst_valid_out", 63'(valid_out), 63'd0);
    check("rst_data_out", 63'(data_out), 63'd0);
    check("rst_data_out_all", data_out_all, 63'd0);

    rst = 1'b1;
    @(negedge clk);
    check("ready_in_after_rst", 63'(ready_in), 63'd1);

    data_in_all = 51'd0;
    @(negedge clk);
    check("par_zero", data_out_all, 63'h0);
    data_in_all = 51'd1;
    @(negedge clk);
    check("par_one", data_out_all, 63'h1539);
    data_in_all = 51'd2;
    @(negedge clk);
    check("par_two", data_out_all, 63'h2A72);
    data_in_all = 51'd4;
    @(negedge clk);
    check("par_four", data_out_all, 63'h41DD);
    data_in_all = 51'd1 << 50;
    @(negedge clk);
    check("par_msb", data_out_all, model_cw(51'd1 << 50));
    data_in_all = LONG_MSG;
    @(negedge clk);
    check("par_long", data_out_all, model_cw(LONG_MSG));
    check("par_long_rem", 63'(poly_rem(data_out_all)), 63'd0);

    load_msg(51'd1, 51, 0, to);
    check("ser1_load_timeout", 63'(to), 63'd0);
    collect(0, cw, rdy_bad, hold_bad, to);
    check("ser1_send_timeout", 63'(to), 63'd0);
    check("ser1_codeword", cw, 63'h1539);
    check("ser1_ready_in_low", 63'(rdy_bad), 63'd0);
    check("ser1_back_valid_out", 63'(valid_out), 63'd0);
    check("ser1_back_ready_in", 63'(ready_in), 63'd1);
    check("ser1_back_data_out", 63'(data_out), 63'd0);

    data_in_all = LONG_MSG;
    load_msg(LONG_MSG, 51, 35, to);
    check("ser2_load_timeout", 63'(to), 63'd0);
    collect(40, cw, rdy_bad, hold_bad, to);
    check("ser2_send_timeout", 63'(to), 63'd0);
    check("ser2_vs_model", cw, model_cw(LONG_MSG));
    check("ser2_vs_parallel", cw, data_out_all);
    check("ser2_rem", 63'(poly_rem(cw)), 63'd0);
    check("ser2_hold", 63'(hold_bad), 63'd0);
    check("ser2_ready_in_low", 63'(rdy_bad), 63'd0);
    check("ser2_back_valid_out", 63'(valid_out), 63'd0);

    load_msg(LONG_MSG, 20, 0, to);
    check("abort_load_timeout", 63'(to), 63'd0);
    @(negedge clk);
    valid_in = 1'b0;
    rst      = 1'b0;
    #1;
    check("abort_valid_out", 63'(valid_out), 63'd0);
    check("abort_ready_in", 63'(ready_in), 63'd0);
    check("abort_data_out", 63'(data_out), 63'd0);
    @(negedge clk);
    rst = 1'b1;
    seen_valid = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (valid_out) seen_valid = 1'b1;
    end
    check("abort_no_output", 63'(seen_valid), 63'd0);
    load_msg(51'd1, 51, 20, to);
    check("abort_reload_timeout", 63'(to), 63'd0);
    collect(20, cw, rdy_bad, hold_bad, to);
    check("abort_send_timeout", 63'(to), 63'd0);
    check("abort_codeword", cw, 63'h1539);

    for (int i = 0; i < 1000; i++) begin
      r64 = {$urandom, $urandom};
      a   = r64[50:0];
      r64 = {$urandom, $urandom};
      b   = r64[50:0];
      @(negedge clk);
      data_in_all = a;
      @(negedge clk);
      ca = data_out_all;
      data_in_all = b;
      @(negedge clk);
      cb = data_out_all;
      data_in_all = a ^ b;
      @(negedge clk);
      cab = data_out_all;
      check("linearity", cab, ca ^ cb);
      if (i < 4) check("rand_vs_model", ca, model_cw(a));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
